hyperbus_axi_rd_burst_splitter: RTL
===================================

Name: hyperbus_axi_rd_burst_splitter

Overview:
- Read-path stage between the 16-bit, 32-bit-address AXI side (output of the address-size converter) and the hyperbus controller's AR/R channels.
- Splits each incoming INCR read burst into sub-bursts that never cross a BOUNDARY-byte HyperRAM row and never exceed MAX_BEATS beats.
- Reassembles the returned R beats into one burst towards the requester, with a single correct s_r_last.
- Allows one sub-burst outstanding at a time.

Parameters:
AW, 32, address width in bits
DW, 16, data width; every beat is 2 bytes (AxSIZE=1), INCR bursts only
IW, 10, ID width
BOUNDARY, 1024, row boundary in bytes; power of two, at least 4
MAX_BEATS, 64, maximum beats per sub-burst; range 1..256

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active high
s_ar_valid  in  1  upstream read request valid
s_ar_ready  out  1  upstream read request accept
s_ar_addr  in  AW  byte start address
s_ar_len  in  8  beats minus 1
s_ar_id  in  IW  transaction ID
s_r_valid  out  1  upstream read data valid
s_r_ready  in  1  upstream read data accept
s_r_data  out  DW  read data
s_r_resp  out  2  per-beat response
s_r_last  out  1  last beat of the original burst
s_r_id  out  IW  stored ID
m_ar_valid  out  1  sub-burst request valid
m_ar_ready  in  1  controller accept
m_ar_addr  out  AW  sub-burst start address
m_ar_len  out  8  sub-burst beats minus 1
m_ar_id  out  IW  stored ID
m_r_valid  in  1  controller data valid
m_r_ready  out  1  controller data accept
m_r_data  in  DW  data
m_r_resp  in  2  response
m_r_last  in  1  controller last flag; checked only

Behaviour:
- Reset values: all outputs 0 while rst_i is high. Internal state is IDLE with counters cleared. s_ar_ready is registered and rises on the first clk_i edge after rst_i falls.
- IDLE:
  - s_ar_ready=1.
  - On s_ar handshake, latch addr, id and rem=len+1 (9 bits). Go to ISSUE; s_ar_ready drops in the same edge.
- ISSUE:
  - m_ar_valid=1 (first cycle is exactly one cycle after the s_ar handshake).
  - m_ar_addr=cur_addr, m_ar_id=id.
  - beats = min(rem, MAX_BEATS, (BOUNDARY - cur_addr mod BOUNDARY)>>1); m_ar_len=beats-1.
  - m_ar_addr, m_ar_len and m_ar_valid stay stable until m_ar_ready.
  - On handshake, load sub_cnt=beats and go to DATA.
- DATA:
  - m_r_ready=s_r_ready.
  - s_r_valid=m_r_valid; data, resp and id pass through combinationally.
  - s_r_last=(rem==1); it is driven by the counter and never by m_r_last.
  - Each beat transferred: rem--, sub_cnt--.
  - When sub_cnt reaches 0 and rem>0: cur_addr += 2*beats (modulo 2^AW, wraps), go to ISSUE.
  - When sub_cnt reaches 0 and rem==0: go to IDLE; s_ar_ready=1 on the next cycle.
- m_r_ready=0 outside DATA. Any m_r_valid outside DATA is ignored (simulation assertion).
- Simulation-only assertions:
  - m_r_last must equal (sub_cnt==1) on every beat.
  - cur_addr[0] must be 0.
- Error responses are forwarded per beat unchanged. Splitting continues; there is no early abort.
- Reset mid-operation abandons the burst immediately. The controller is reset together with this block.
- Address bit 0 is ignored for the split arithmetic and driven as 0.

Test Plan:
- Request addr 0x100, len 15 -> one m_ar with addr 0x100, len 15; 16 beats forwarded in order; s_r_last only on beat 16; s_ar_ready high 1 cycle after the last beat.
- Request addr 0x3F0, len 15 -> m_ar 0x3F0 len 7, then m_ar 0x400 len 7; s_r_last only on beat 16; s_r_id equals the request ID throughout.
- Request addr 0x0, len 255 with MAX_BEATS=64 -> four m_ar at 0x000, 0x080, 0x100, 0x180, each len 63; 256 beats, single s_r_last.
- Request addr 0xFFFFFFFE, len 1 -> m_ar 0xFFFFFFFE len 0, then 0x00000000 len 0 (wrap).
- Random 50% stalls on s_r_ready and m_ar_ready, plus SLVERR on beat 3 -> no beat lost or duplicated; resp=2 seen on upstream beat 3 only; m_ar fields stable while stalled.
- Assert rst_i after beat 5 of a 32-beat burst -> all outputs 0 in the same cycle; after release, a new request (addr 0x40, len 3) completes normally.

Source files
------------

// File: rtl/hyperbus_axi_rd_burst_splitter_if.sv
// AXI read address + read data channel bundle (AR/R), 16-bit data path.
interface hyperbus_axi_rd_burst_splitter_if #(
  parameter int AW = 32,
  parameter int DW = 16,
  parameter int IW = 10
);
  logic          ar_valid;
  logic          ar_ready;
  logic [AW-1:0] ar_addr;
  logic [7:0]    ar_len;
  logic [IW-1:0] ar_id;
  logic          r_valid;
  logic          r_ready;
  logic [DW-1:0] r_data;
  logic [1:0]    r_resp;
  logic          r_last;
  logic [IW-1:0] r_id;

  // Side that issues read requests and consumes read data
  modport master (
    output ar_valid, ar_addr, ar_len, ar_id, r_ready,
    input  ar_ready, r_valid, r_data, r_resp, r_last, r_id
  );

  // Side that accepts read requests and returns read data
  modport slave (
    input  ar_valid, ar_addr, ar_len, ar_id, r_ready,
    output ar_ready, r_valid, r_data, r_resp, r_last, r_id
  );
endinterface

// File: rtl/hyperbus_axi_rd_burst_splitter.sv
// Splits INCR read bursts into row-safe, length-capped sub-bursts towards the
// hyperbus controller and stitches the returned beats back into one burst.
// One sub-burst outstanding at a time.
module hyperbus_axi_rd_burst_splitter #(
  parameter int AW        = 32,
  parameter int DW        = 16,
  parameter int IW        = 10,
  parameter int BOUNDARY  = 1024,
  parameter int MAX_BEATS = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  hyperbus_axi_rd_burst_splitter_if.slave  s,
  hyperbus_axi_rd_burst_splitter_if.master m
);
  localparam int BW = $clog2(BOUNDARY);

  typedef enum logic [1:0] {IDLE, ISSUE, DATA} state_t;

  state_t        state, state_nxt;
  logic          rdy_q;
  logic [AW-1:0] cur_addr;
  logic [IW-1:0] id_q;
  logic [8:0]    rem;
  logic [8:0]    sub_cnt;
  logic [BW:0]   room;
  logic [8:0]    beats;
  int            beats_i;
  logic          beat;

  // Bytes left in the current row; cur_addr is always even so this is >= 2
  assign room = (BW+1)'(BOUNDARY) - {1'b0, cur_addr[BW-1:0]};
  assign beat = (state == DATA) && m.r_valid && s.r_ready;

  // Sub-burst size: smallest of remaining beats, MAX_BEATS and beats to row end
  always_comb begin
    beats_i = int'(rem);
    if (beats_i > MAX_BEATS) beats_i = MAX_BEATS;
    if (beats_i > int'(room[BW:1])) beats_i = int'(room[BW:1]);
    beats = 9'(beats_i);
  end

  // Next state and all channel outputs; everything is 0 outside its state
  always_comb begin
    state_nxt  = state;
    s.ar_ready = rdy_q;
    m.ar_valid = 1'b0;
    m.ar_addr  = '0;
    m.ar_len   = '0;
    m.ar_id    = '0;
    m.r_ready  = 1'b0;
    s.r_valid  = 1'b0;
    s.r_data   = '0;
    s.r_resp   = '0;
    s.r_last   = 1'b0;
    s.r_id     = '0;
    case (state)
      IDLE: if (s.ar_valid && rdy_q) state_nxt = ISSUE;
      ISSUE: begin
        m.ar_valid = 1'b1;
        m.ar_addr  = cur_addr;
        m.ar_len   = 8'(beats - 9'd1);
        m.ar_id    = id_q;
        if (m.ar_ready) state_nxt = DATA;
      end
      DATA: begin
        m.r_ready = s.r_ready;
        s.r_valid = m.r_valid;
        s.r_data  = m.r_data;
        s.r_resp  = m.r_resp;
        s.r_last  = (rem == 9'd1);
        s.r_id    = id_q;
        if (beat && sub_cnt == 9'd1) state_nxt = (rem == 9'd1) ? IDLE : ISSUE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counters and address; cur_addr advances as soon as a sub-burst is
  // accepted since it is only presented again in the next ISSUE
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      rdy_q    <= 1'b0;
      cur_addr <= '0;
      id_q     <= '0;
      rem      <= '0;
      sub_cnt  <= '0;
    end else begin
      state <= state_nxt;
      rdy_q <= (state_nxt == IDLE);
      if (state == IDLE && s.ar_valid && rdy_q) begin
        cur_addr <= s.ar_addr & ~AW'(1);
        id_q     <= s.ar_id;
        rem      <= 9'(s.ar_len) + 9'd1;
      end
      if (state == ISSUE && m.ar_ready) begin
        sub_cnt  <= beats;
        cur_addr <= cur_addr + AW'({beats, 1'b0});
      end
      if (beat) begin
        rem     <= rem - 9'd1;
        sub_cnt <= sub_cnt - 9'd1;
      end
    end
  end

  // Simulation-only sanity checks on controller behaviour and address alignment
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (beat) assert (m.r_last == (sub_cnt == 9'd1));
      assert (!(m.r_valid && state != DATA));
      assert (!cur_addr[0]);
    end
  end
endmodule
